// File: rtl/synth_pkg.sv
// Shared constants and sample type for the synth output path.
package synth_pkg;
  localparam int SAMPLE_RATE    = 48000;
  localparam int SAMPLE_WIDTH   = 16;
  localparam int I2S_SLOT_WIDTH = 32;
  localparam int I2S_FRAME_BITS = 2 * I2S_SLOT_WIDTH;
  localparam int I2S_REQ_BIT    = I2S_FRAME_BITS - 2;

  typedef logic signed [SAMPLE_WIDTH-1:0] sample_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } i2s_state_e;
endpackage

// File: rtl/i2s_bclk_gen.sv
// BCLK divider: toggles bclk every CLK_DIV clk cycles while en is high.
// Latency: bclk is registered; fall is a combinational strobe in the cycle before bclk drops.
// Backpressure: none, free-running once enabled.
module i2s_bclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic bclk,
  output logic fall
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             wrap;

  assign wrap = en && (div_cnt == DIV_LAST);
  assign fall = wrap && bclk;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (en) begin
      if (wrap) begin
        div_cnt <= '0;
        bclk    <= ~bclk;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter: paces upstream with sample_req and sends the mono sample MSB-first on both slots.
// Latency: sample captured in frame N is transmitted in frame N+1, MSB at bit 1 of each slot.
// Backpressure: none; upstream must present sample_in in the cycle after sample_req.
module i2s_tx
  import synth_pkg::*;
#(
  parameter int CLK_DIV      = 4,
  parameter int SAMPLE_WIDTH = synth_pkg::SAMPLE_WIDTH,
  parameter int SLOT_WIDTH   = I2S_SLOT_WIDTH
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic signed [SAMPLE_WIDTH-1:0] sample_in,
  output logic                           sample_req,
  output logic                           bclk,
  output logic                           lrclk,
  output logic                           sdata
);
  localparam int FRAME_BITS = 2 * SLOT_WIDTH;
  localparam int BIT_W      = $clog2(FRAME_BITS);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_BITS - 1);
  localparam logic [BIT_W-1:0] REQ_BIT  = BIT_W'(FRAME_BITS - 2);
  localparam logic [BIT_W-1:0] SLOT_BIT = BIT_W'(SLOT_WIDTH);
  localparam logic [BIT_W-1:0] SW_BIT   = BIT_W'(SAMPLE_WIDTH);
  localparam logic [SAMPLE_WIDTH-1:0] BIT0 = SAMPLE_WIDTH'(1);

  i2s_state_e state, state_nxt;
  logic                    run;
  logic                    fall;
  logic [BIT_W-1:0]        bit_idx, bit_nxt, slot_pos, tap;
  logic                    lrclk_nxt, sdata_nxt;
  logic                    cap_pend;
  logic [SAMPLE_WIDTH-1:0] hold_reg, shift_reg;

  assign run = (state == ST_RUN);

  i2s_bclk_gen #(.CLK_DIV(CLK_DIV)) u_bclk_gen (
    .clk   (clk),
    .reset (reset),
    .en    (run),
    .bclk  (bclk),
    .fall  (fall)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: state_nxt = ST_RUN;
      ST_RUN:  state_nxt = ST_RUN;
    endcase
  end

  // Outputs are computed for the bit about to start, so they change together with b.
  always_comb begin
    bit_nxt   = (bit_idx == LAST_BIT) ? '0 : bit_idx + 1'b1;
    lrclk_nxt = (bit_nxt >= SLOT_BIT);
    slot_pos  = lrclk_nxt ? (bit_nxt - SLOT_BIT) : bit_nxt;
    tap       = SW_BIT - slot_pos;
    sdata_nxt = 1'b0;
    if ((slot_pos != '0) && (slot_pos <= SW_BIT))
      sdata_nxt = |(shift_reg & (BIT0 << tap));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_idx    <= '0;
      lrclk      <= 1'b0;
      sdata      <= 1'b0;
      sample_req <= 1'b0;
      cap_pend   <= 1'b0;
      hold_reg   <= '0;
      shift_reg  <= '0;
    end else begin
      sample_req <= fall && (bit_nxt == REQ_BIT);
      cap_pend   <= sample_req;
      // Upstream gets the full cycle after sample_req to settle its output.
      if (cap_pend) hold_reg <= sample_in;
      if (fall) begin
        bit_idx <= bit_nxt;
        lrclk   <= lrclk_nxt;
        sdata   <= sdata_nxt;
        if (bit_nxt == '0) shift_reg <= hold_reg;
      end
    end
  end
endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx at CLK_DIV=4 and CLK_DIV=1: cycle model plus an I2S receiver per DUT.
module tb_i2s_tx;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic signed [15:0] s4, s1;
  logic req4, bclk4, lr4, sd4;
  logic req1, bclk1, lr1, sd1;

  always #5 clk = ~clk;

  i2s_tx #(.CLK_DIV(4)) dut4 (
    .clk(clk), .reset(reset), .sample_in(s4),
    .sample_req(req4), .bclk(bclk4), .lrclk(lr4), .sdata(sd4)
  );
  i2s_tx #(.CLK_DIV(1)) dut1 (
    .clk(clk), .reset(reset), .sample_in(s1),
    .sample_req(req1), .bclk(bclk1), .lrclk(lr1), .sdata(sd1)
  );

  int tests = 0;
  int fails = 0;
  int r = -1;      // run-cycle index since RUN entry; -1 in reset/idle
  int epoch = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Expected {bclk, lrclk, sdata, sample_req} in run cycle rr for divider d.
  function automatic logic [3:0] model(int rr, int d, logic [15:0] smp);
    int ph, b, pos;
    logic sd;
    ph  = rr % (128 * d);
    b   = ph / (2 * d);
    pos = b % 32;
    sd  = 1'b0;
    if (pos >= 1 && pos <= 16) sd = smp[16-pos];
    return {(rr % (2 * d)) >= d, b >= 32, sd, ph == 62 * 2 * d};
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) r <= -1;
    else        r <= r + 1;
  end

  logic [15:0] pl4 [int];
  logic [15:0] pl1 [int];
  int reqt4 [2], reqt1 [2], rise4 [2], rise1 [2];
  int nreq4 = 0, nreq1 = 0, nrise4 = 0, nrise1 = 0;
  logic pb4 = 1'b0, pb1 = 1'b0;

  always @(negedge clk) begin : mon
    int f;
    logic [15:0] smp;
    if (!reset || r < 0) begin
      chk("idle_out4", 32'({bclk4, lr4, sd4, req4}), 32'h0);
      chk("idle_out1", 32'({bclk1, lr1, sd1, req1}), 32'h0);
      if (!reset) begin
        pl4.delete();
        pl1.delete();
      end
      pb4 = 1'b0;
      pb1 = 1'b0;
    end else begin
      f   = r / 512;
      smp = pl4.exists(f) ? pl4[f] : 16'h0;
      chk("out4", 32'({bclk4, lr4, sd4, req4}), 32'(model(r, 4, smp)));
      if (r % 512 == 497) pl4[f+1] = s4;
      f   = r / 128;
      smp = pl1.exists(f) ? pl1[f] : 16'h0;
      chk("out1", 32'({bclk1, lr1, sd1, req1}), 32'(model(r, 1, smp)));
      if (r % 128 == 125) pl1[f+1] = s1;
      if (req4 && nreq4 < 2) begin reqt4[nreq4] = r; nreq4++; end
      if (req1 && nreq1 < 2) begin reqt1[nreq1] = r; nreq1++; end
      if (bclk4 && !pb4 && nrise4 < 2) begin rise4[nrise4] = r; nrise4++; end
      if (bclk1 && !pb1 && nrise1 < 2) begin rise1[nrise1] = r; nrise1++; end
      pb4 = bclk4;
      pb1 = bclk1;
    end
  end

  // Codec-side receivers: a word starts at the first BCLK rise after an lrclk change.
  logic [15:0] w4, w1;
  int p4, p1;
  logic plr4, plr1;
  logic [15:0] q4 [$];
  logic [15:0] q1 [$];

  always @(posedge bclk4 or negedge reset) begin
    if (!reset) begin
      p4 = 0; plr4 = 1'b1;
    end else begin
      if (lr4 != plr4) p4 = 0; else p4++;
      plr4 = lr4;
      if (p4 >= 1 && p4 <= 16) w4[16-p4] = sd4;
      if (p4 == 16) q4.push_back(w4);
    end
  end

  always @(posedge bclk1 or negedge reset) begin
    if (!reset) begin
      p1 = 0; plr1 = 1'b1;
    end else begin
      if (lr1 != plr1) p1 = 0; else p1++;
      plr1 = lr1;
      if (p1 >= 1 && p1 <= 16) w1[16-p1] = sd1;
      if (p1 == 16) q1.push_back(w1);
    end
  end

  logic [15:0] exp4 [17] = '{16'h0000, 16'h0000, 16'hA5C3, 16'hA5C3, 16'h8000, 16'h8000,
                             16'hFFFF, 16'hFFFF, 16'h1234, 16'h1234, 16'h5A5A,
                             16'h0000, 16'h0000, 16'h0F0F, 16'h0F0F, 16'h0F0F, 16'h0F0F};
  logic [15:0] exp1 [6] = '{16'h0000, 16'h0000, 16'h00FF, 16'h00FF, 16'h00FF, 16'h00FF};

  initial begin
    int f, ph;
    bit done;
    done = 1'b0;
    s4 = 16'hA5C3;
    s1 = 16'h00FF;
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    for (int c = 0; c < 10000 && !done; c++) begin
      @(posedge clk);
      #1;
      if (epoch == 0 && r >= 0) begin
        f  = r / 512;
        ph = r % 512;
        case (f)
          0:       s4 = 16'hA5C3;
          1:       s4 = 16'h8000;
          2:       s4 = 16'hFFFF;
          3:       s4 = (ph == 497) ? 16'h1234 : 16'($urandom);
          default: s4 = 16'h5A5A;
        endcase
        if (f == 5 && ph == 322) begin
          chk("lrclk_before_reset", 32'(lr4), 32'h1);
          reset = 1'b0;
          #1;
          chk("async_reset4", 32'({bclk4, lr4, sd4, req4}), 32'h0);
          chk("async_reset1", 32'({bclk1, lr1, sd1, req1}), 32'h0);
          repeat (3) @(posedge clk);
          #1 reset = 1'b1;
          s4 = 16'h0F0F;
          epoch = 1;
        end
      end else if (epoch == 1 && r >= 3 * 512) begin
        done = 1'b1;
      end
    end
    chk("run_completed", 32'(done), 32'h1);

    chk("first_req4", 32'(reqt4[0]), 32'd496);
    chk("req4_period", 32'(reqt4[1] - reqt4[0]), 32'd512);
    chk("first_req1", 32'(reqt1[0]), 32'd124);
    chk("req1_period", 32'(reqt1[1] - reqt1[0]), 32'd128);
    chk("first_rise4", 32'(rise4[0]), 32'd4);
    chk("bclk4_period", 32'(rise4[1] - rise4[0]), 32'd8);
    chk("first_rise1", 32'(rise1[0]), 32'd1);
    chk("bclk1_period", 32'(rise1[1] - rise1[0]), 32'd2);

    for (int i = 0; i < 17; i++)
      chk($sformatf("word4_%0d", i), (i < q4.size()) ? 32'(q4[i]) : 32'hDEAD0000, 32'(exp4[i]));
    for (int i = 0; i < 6; i++)
      chk($sformatf("word1_%0d", i), (i < q1.size()) ? 32'(q1[i]) : 32'hDEAD0000, 32'(exp1[i]));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/i2s_tx.md
# i2s_tx

Audio codec transmitter for the synth output path. Generates the 48 kHz sample request that paces the envelope and oscillator chain (their `in_ready`), captures the resulting 16-bit signed sample, and serializes it MSB-first onto a standard I2S link (BCLK, LRCLK, SDATA). The same mono sample is sent on both left and right channels.

## Interface
- `CLK_DIV`, 4: `clk` cycles per BCLK half-period, ≥1. BCLK = clk/(2·CLK_DIV); 24.576 MHz clk with CLK_DIV=4 gives 3.072 MHz BCLK and 48 kHz frames.
- `SAMPLE_WIDTH`, 16: sample bits per channel, ≤ `SLOT_WIDTH`-1.
- `SLOT_WIDTH`, 32: BCLK periods per channel slot. Frame = 2·SLOT_WIDTH bits.
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  asynchronous, active-low reset.
- `sample_in`  in  SAMPLE_WIDTH  signed sample from the envelope stage.
- `sample_req`  out  1  one-`clk` pulse per frame requesting the next sample; drives the upstream `in_ready`.
- `bclk`  out  1  I2S bit clock.
- `lrclk`  out  1  I2S word select; 0 = left, 1 = right.
- `sdata`  out  1  I2S serial data.

## Operation
- Divider counter `div_cnt` counts 0..CLK_DIV-1. On the cycle with `div_cnt`==CLK_DIV-1 it wraps and `bclk` toggles.
- Bit index `b` counts 0..2·SLOT_WIDTH-1 and wraps to 0. It advances only on a 1→0 `bclk` toggle. `lrclk` and `sdata` update on that same `clk` edge, so the codec sees stable data on each BCLK rising edge.
- `lrclk` = 0 for b in 0..SLOT_WIDTH-1 and 1 for the rest of the frame.
- I2S one-bit delay: at b = k, for k in 1..SAMPLE_WIDTH, `sdata` = sample[SAMPLE_WIDTH-k] (left). At b = SLOT_WIDTH+k it carries the same bits (right). All other b drive 0.
- Sample handshake:
  - `sample_req` is high for exactly one `clk` cycle: the cycle immediately after the edge on which b becomes 2·SLOT_WIDTH-2.
  - `sample_in` is captured into the holding register on the rising edge that ends the cycle *after* the `sample_req` cycle. This gives upstream one full cycle to update on its `in_ready`.
  - `sample_in` on any other cycle is ignored.
- The holding register is copied into the transmit shift register on the edge on which b becomes 0. The sample captured during frame N is therefore transmitted in frame N+1.
- States:
  - IDLE: reset only.
  - RUN: free-running divider plus bit index.
  - RUN is entered on the first `clk` edge after reset deasserts. No other state exists, and no stall or backpressure input exists.

## Timing
- Reset (asynchronous, immediate) forces:
  - `bclk`=0, `lrclk`=0, `sdata`=0, `sample_req`=0.
  - `div_cnt`=0, b=0, holding and shift registers = 0.
- First frame after reset starts at b=0 and transmits zeros. Its `sample_req` falls at b=2·SLOT_WIDTH-2, and that sample plays in frame 1.
- BCLK period = 2·CLK_DIV clks. Frame = 4·SLOT_WIDTH·CLK_DIV clks (512 for defaults). `sample_req` period equals the frame length exactly.
- Sample-to-first-bit latency is deterministic: from the capture edge to the MSB appearing at b=1 of the next frame.
- Reset asserted mid-frame aborts the frame. Outputs go to reset values without waiting for `clk`, and the next frame restarts at b=0 with a zero sample.
- CLK_DIV=1: `bclk` toggles every `clk`. All relations above still hold.

## Structure
- Shared package `synth_pkg` holds:
  - `SAMPLE_RATE`=48000, `I2S_SLOT_WIDTH`=32, `I2S_FRAME_BITS`=64.
  - Request bit index `I2S_REQ_BIT` = frame bits - 2.
  - The `SAMPLE_WIDTH`=16 sample type shared with the envelope and oscillators.
- One sub-module, `i2s_bclk_gen`: divider plus `bclk` register. It outputs a `fall` strobe (the 1→0 toggle cycle) consumed by the bit counter and serializer in `i2s_tx`.

## Test plan
- Reset held, then released, defaults: all outputs 0 during reset; `bclk` period 8 clks; `sample_req` pulses exactly every 512 clks, first one during b=62 of frame 0.
- `sample_in`=16'hA5C3 held: frame 1 `sdata` at b=1..16 and b=33..48 is 1010010111000011; b=0, 17..32 and 49..63 are 0; `lrclk` toggles at b=0 and b=32.
- `sample_in`=16'h8000 (most negative): MSB 1 followed by fifteen 0s in both slots; with 16'hFFFF, sixteen 1s then zeros.
- `sample_in` changed every clk except the capture cycle, with 16'h1234 on the capture cycle: the next frame transmits only 16'h1234.
- Reset pulsed for 3 clks at b=40: `sdata`/`bclk`/`lrclk`/`sample_req` go 0 asynchronously; after release a full zero frame, then the next captured sample.
- CLK_DIV=1: `bclk` = clk/2, frame = 128 clks, one `sample_req` per frame, 16'h00FF serialized correctly in both slots.
